// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard.
//
// Holds the default index/latency widths, the latency codes used by the
// issue logic for each producer class, and the hardwired zero register index.
// Nothing in here has ports; it is imported by hazard_scoreboard and
// scoreboard_entry.
package hazard_pkg;

  // Default widths: 32 architectural registers, latencies up to 7 cycles.
  localparam int REG_W_DEF = 5;
  localparam int LAT_W_DEF = 3;

  // Cycles from issue until the producer's result can be forwarded.
  // A value of 0 means the result is forwardable the very next cycle, so the
  // destination is never marked busy.
  localparam int LAT_ALU       = 0;
  localparam int LAT_LOAD      = 1;
  localparam int LAT_MUL       = 3;
  localparam int LAT_LOAD_MISS = 6;

  // Register 0 reads as zero and is never a real producer or consumer.
  localparam int ZERO_REG = 0;

  typedef logic [REG_W_DEF-1:0] reg_idx_t;
  typedef logic [LAT_W_DEF-1:0] lat_t;

  // Producer classes the issue logic maps onto the latency codes above.
  typedef enum logic [1:0] {
    PROD_ALU       = 2'd0,
    PROD_LOAD      = 2'd1,
    PROD_MUL       = 2'd2,
    PROD_LOAD_MISS = 2'd3
  } prod_class_e;

  // Latency code for a producer class at the default latency width.
  function automatic lat_t class_lat(input prod_class_e cls);
    lat_t lat;
    case (cls)
      PROD_LOAD:      lat = lat_t'(LAT_LOAD);
      PROD_MUL:       lat = lat_t'(LAT_MUL);
      PROD_LOAD_MISS: lat = lat_t'(LAT_LOAD_MISS);
      default:        lat = lat_t'(LAT_ALU);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: a countdown of cycles until the register's pending
// result becomes forwardable.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset, clears the countdown
//   freeze    in   global pipeline freeze; countdown holds, no load accepted
//   load      in   a new producer for this register issues this cycle
//   load_lat  in   latency of that producer (0 = not busy)
//   busy      out  countdown nonzero: consumers must stall
module scoreboard_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             load,
  input  logic [LAT_W-1:0] load_lat,
  output logic             busy
);

  logic [LAT_W-1:0] cnt;

  // Load beats decrement so the newest producer's latency always wins,
  // even when it is shorter than what was still outstanding (WAW).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_lat;
      end else if (cnt != '0) begin
        cnt <= cnt - LAT_W'(1);
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard.
//
// Tracks, per architectural register, how many cycles remain before the
// in-flight producer's result can be forwarded. The instruction sitting in
// IF/ID is held (PC and IF/ID not written, bubble injected into ID/EX) while
// any of its used sources is still pending.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   src_idx       in   source register indices of IF/ID instruction, src0 in LSBs
//   src_used      in   per-source valid
//   issue_valid   in   ID/EX accepts a new instruction this cycle
//   issue_we      in   that instruction writes a register
//   issue_rd      in   its destination register
//   issue_lat     in   its latency until forwardable (0 = ALU)
//   pipe_freeze   in   global memory stall; all state holds
//   kill          in   squash of the issuing instruction
//   write_pc      out  PC write enable
//   write_ifid    out  IF/ID write enable
//   flush_ctrl    out  zero the control bits going into ID/EX
//   busy_vec      out  per-register pending flags
//   stall_cycles  out  saturating count of unfrozen hazard cycles
//
// The hazard does not gate issue internally: the datapath presents the bubble
// (issue_valid=0 or issue_we=0) while flush_ctrl is high.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = REG_W_DEF,
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int PERF_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*REG_W-1:0] src_idx,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic                     pipe_freeze,
  input  logic                     kill,
  output logic                     write_pc,
  output logic                     write_ifid,
  output logic                     flush_ctrl,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [PERF_W-1:0]        stall_cycles
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  logic               issue_rec;
  logic [NUM_SRC-1:0] src_hit;
  logic               hazard;

  // Writes to the zero register and squashed issues leave no trace.
  assign issue_rec = issue_valid && issue_we && !kill &&
                     (issue_rd != REG_W'(ZERO_REG));

  // Register 0 has no storage and is never pending.
  assign busy_vec[ZERO_REG] = 1'b0;

  // Issue stage: per-register countdown entries
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic load_en;
    assign load_en = issue_rec && (issue_rd == REG_W'(r));

    scoreboard_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .freeze   (pipe_freeze),
      .load     (load_en),
      .load_lat (issue_lat),
      .busy     (busy_vec[r])
    );
  end

  // Decode stage: compare each used source against the pending set.
  // Starting r at 1 keeps a source of register 0 from ever matching.
  always_comb begin
    src_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (src_used[i] && (src_idx[i*REG_W +: REG_W] == REG_W'(r)) && busy_vec[r]) begin
          src_hit[i] = 1'b1;
        end
      end
    end
  end

  // Several sources naming the same busy register still yield one hazard.
  assign hazard     = |src_hit;
  assign write_pc   = !hazard;
  assign write_ifid = !hazard;
  assign flush_ctrl = hazard;

  // Frozen cycles are memory stalls, not hazard stalls, so they are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (!pipe_freeze && hazard) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default-width instance plus a
// PERF_W=4 instance sharing the same stimulus for the saturation case.
module tb_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int NUM_SRC  = 2;
  localparam int LAT_W    = 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_SRC*REG_W-1:0] src_idx = '0;
  logic [NUM_SRC-1:0]       src_used = '0;
  logic                     issue_valid = 1'b0;
  logic                     issue_we = 1'b0;
  logic [REG_W-1:0]         issue_rd = '0;
  logic [LAT_W-1:0]         issue_lat = '0;
  logic                     pipe_freeze = 1'b0;
  logic                     kill = 1'b0;

  logic                write_pc, write_ifid, flush_ctrl;
  logic [NUM_REGS-1:0] busy_vec;
  logic [31:0]         stall_cycles;

  logic                write_pc_s, write_ifid_s, flush_ctrl_s;
  logic [NUM_REGS-1:0] busy_vec_s;
  logic [3:0]          stall_cycles_s;

  int checks = 0;
  int errors = 0;
  int stall_n;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .src_idx      (src_idx),
    .src_used     (src_used),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .pipe_freeze  (pipe_freeze),
    .kill         (kill),
    .write_pc     (write_pc),
    .write_ifid   (write_ifid),
    .flush_ctrl   (flush_ctrl),
    .busy_vec     (busy_vec),
    .stall_cycles (stall_cycles)
  );

  hazard_scoreboard #(.PERF_W(4)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .src_idx      (src_idx),
    .src_used     (src_used),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .pipe_freeze  (pipe_freeze),
    .kill         (kill),
    .write_pc     (write_pc_s),
    .write_ifid   (write_ifid_s),
    .flush_ctrl   (flush_ctrl_s),
    .busy_vec     (busy_vec_s),
    .stall_cycles (stall_cycles_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1ns after it, well away from the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    src_idx     = '0;
    src_used    = '0;
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_rd    = '0;
    issue_lat   = '0;
    pipe_freeze = 1'b0;
    kill        = 1'b0;
  endtask

  task automatic issue(input int rd, input int lat, input logic k);
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_rd    = REG_W'(rd);
    issue_lat   = LAT_W'(lat);
    kill        = k;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    kill        = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_busy", busy_vec, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_wpc", write_pc, 1);
    check("rst_wifid", write_ifid, 1);
    check("rst_flush", flush_ctrl, 0);
    check("rst_sat_stall", stall_cycles_s, 0);
    check("rst_sat_wpc", write_pc_s, 1);

    // Classic load-use: rd=5 lat=1, consumer next cycle stalls once
    issue(5, 1, 1'b0);
    tick();
    no_issue();
    src_idx  = {5'd0, 5'd5};
    src_used = 2'b01;
    #1;
    check("lu_t1_wpc", write_pc, 0);
    check("lu_t1_wifid", write_ifid, 0);
    check("lu_t1_flush", flush_ctrl, 1);
    check("lu_t1_busy5", busy_vec[5], 1);
    tick();
    check("lu_t2_wpc", write_pc, 1);
    check("lu_t2_flush", flush_ctrl, 0);
    check("lu_t2_stall", stall_cycles, 1);

    // Multiply chain with freeze: 3 hazard cycles stretched to 5
    do_reset();
    issue(8, 3, 1'b0);
    tick();
    no_issue();
    src_idx  = {5'd8, 5'd0};
    src_used = 2'b10;
    stall_n  = 0;
    for (int c = 0; c < 8; c++) begin
      pipe_freeze = (c == 1 || c == 2);
      #1;
      if (!write_pc) stall_n++;
      tick();
    end
    pipe_freeze = 1'b0;
    check("mul_stall_cycles_seen", stall_n, 5);
    check("mul_perf", stall_cycles, 3);
    check("mul_busy_clear", busy_vec, 0);

    // WAW: newer shorter latency wins
    do_reset();
    issue(7, 6, 1'b0);
    tick();
    issue(7, 1, 1'b0);
    tick();
    no_issue();
    check("waw_busy7_pending", busy_vec[7], 1);
    tick();
    check("waw_busy7_clear", busy_vec[7], 0);

    // Kill suppresses issue
    issue(9, 4, 1'b1);
    tick();
    no_issue();
    check("kill_busy9", busy_vec[9], 0);
    check("kill_busy_all", busy_vec, 0);

    // ALU latency 0 never marks busy
    issue(10, 0, 1'b0);
    tick();
    no_issue();
    check("alu_busy10", busy_vec[10], 0);

    // Zero register as destination and as source
    issue(0, 6, 1'b0);
    tick();
    no_issue();
    check("zero_dest_busy", busy_vec, 0);
    src_idx  = {5'd0, 5'd0};
    src_used = 2'b11;
    #1;
    check("zero_src_wpc", write_pc, 1);

    // Unused source, then both sources naming the same busy register
    do_reset();
    issue(3, 3, 1'b0);
    tick();
    no_issue();
    src_idx  = {5'd0, 5'd3};
    src_used = 2'b10;
    #1;
    check("unused_wpc", write_pc, 1);
    check("unused_flush", flush_ctrl, 0);
    src_idx  = {5'd3, 5'd3};
    src_used = 2'b11;
    #1;
    check("dup_flush", flush_ctrl, 1);
    tick();
    check("dup_perf_single", stall_cycles, 1);

    // Saturation: keep r4 pending by re-issuing every cycle
    do_reset();
    issue(4, 7, 1'b0);
    src_idx  = {5'd0, 5'd4};
    src_used = 2'b01;
    tick();
    for (int c = 0; c < 20; c++) tick();
    check("sat_perf4", stall_cycles_s, 15);
    check("sat_perf32", stall_cycles, 20);
    check("sat_mid_flush", flush_ctrl, 1);

    // Async reset mid-stall: non-stalling before the next edge
    #2 reset = 1'b0;
    #1;
    check("areset_wpc", write_pc, 1);
    check("areset_wifid", write_ifid, 1);
    check("areset_flush", flush_ctrl, 0);
    check("areset_busy", busy_vec, 0);
    check("areset_perf", stall_cycles, 0);
    check("areset_sat_perf", stall_cycles_s, 0);
    set_idle();
    tick();
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
